// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: streams operand pairs into a DSP48A1-style MAC slice
// and hands the finished dot product back through a valid/ready port.
module dsp_mac_sequencer #(
  parameter int N_TAPS       = 4,
  parameter int DSP_LATENCY  = 3,
  parameter int OPMODE_DELAY = 1
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [17:0] IN_A,
  input  logic [17:0] IN_B,
  output logic [17:0] A,
  output logic [17:0] B,
  output logic [17:0] D,
  output logic [7:0]  OPMODE,
  output logic        CARRYIN,
  input  logic [47:0] P,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [47:0] OUT_DATA
);

  localparam logic [7:0] OP_FIRST = 8'b0000_0001;
  localparam logic [7:0] OP_ACC   = 8'b0000_1001;
  localparam logic [7:0] OP_HOLD  = 8'b0000_1000;
  localparam logic [7:0] LAST_TAP = 8'(N_TAPS - 1);
  localparam logic [7:0] LAT      = 8'(DSP_LATENCY);

  typedef enum logic [1:0] {
    ISSUE,
    DRAIN,
    HOLD
  } state_t;

  state_t     state;
  logic [7:0] tap;
  logic [7:0] dcnt;
  logic [7:0] opq [OPMODE_DELAY+1];
  logic       take;
  logic [7:0] tap_op;

  assign take = IN_VALID && IN_READY;

  always_comb begin
    tap_op = OP_ACC;
    unique case (1'b1)
      (tap == 8'd0): tap_op = OP_FIRST;
      (tap != 8'd0): tap_op = OP_ACC;
    endcase
  end

  assign D       = '0;
  assign CARRYIN = 1'b0;
  assign OPMODE  = opq[OPMODE_DELAY];

  // Stage 0 lines up with A/B; the tail reaches the slice later.
  always_ff @(posedge clk) begin
    if (RST) begin
      for (int i = 0; i <= OPMODE_DELAY; i++)
        opq[i] <= OP_HOLD;
    end else begin
      opq[0] <= take ? tap_op : OP_HOLD;
      for (int i = 1; i <= OPMODE_DELAY; i++)
        opq[i] <= opq[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= ISSUE;
      tap       <= '0;
      dcnt      <= '0;
      A         <= '0;
      B         <= '0;
      IN_READY  <= 1'b0;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
    end else begin
      A <= take ? IN_A : '0;
      B <= take ? IN_B : '0;
      unique case (state)
        ISSUE: begin
          IN_READY <= 1'b1;
          if (take) begin
            if (tap == LAST_TAP) begin
              tap      <= '0;
              dcnt     <= '0;
              IN_READY <= 1'b0;
              state    <= DRAIN;
            end else begin
              tap <= tap + 8'd1;
            end
          end
        end
        DRAIN: begin
          if (dcnt == LAT) begin
            OUT_DATA  <= P;
            OUT_VALID <= 1'b1;
            state     <= HOLD;
          end else begin
            dcnt <= dcnt + 8'd1;
          end
        end
        HOLD: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            IN_READY  <= 1'b1;
            state     <= ISSUE;
          end
        end
        default: begin
          state    <= ISSUE;
          IN_READY <= 1'b0;
        end
      endcase
    end
  end

endmodule
